lcd_note_writer: RTL



---
 rtl/lcd_note_writer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_note_writer.sv
// lcd_note_writer
// ---------------------------------------------------------------------------
// Drives an HD44780-compatible 16x2 character LCD in 8-bit write-only mode and
// keeps the four-character note name from the note-to-character stage on
// screen. After reset it waits for the LCD to power up, runs the init command
// sequence, and then rewrites the four characters whenever the input word
// differs from the last value written.
//
// Ports:
//   clk          system clock (50 MHz nominal)
//   reset_n      asynchronous active-low reset
//   note_chars   four ASCII characters, [31:24] leftmost, [7:0] rightmost
//   lcd_data     LCD DB7..DB0
//   lcd_rs       0 = command byte, 1 = data byte
//   lcd_rw       tied low (write only)
//   lcd_en       LCD enable strobe
//   init_done    high once the init sequence has completed (sticky)
//   busy         high while powering up, initialising or writing
//   update_count number of completed display updates, wraps 255 -> 0
// ---------------------------------------------------------------------------
module lcd_note_writer #(
    parameter int EN_HIGH_CYCLES    = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000,
    parameter int POWERUP_CYCLES    = 1000000,
    parameter int START_COL         = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] note_chars,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        init_done,
    output logic        busy,
    output logic [7:0]  update_count
);

    // One shared counter times power-up, the enable pulse and the post-byte
    // waits, so it is sized for the longest of them.
    localparam int MAX_A    = (EN_HIGH_CYCLES > CMD_WAIT_CYCLES) ? EN_HIGH_CYCLES : CMD_WAIT_CYCLES;
    localparam int MAX_B    = (CLEAR_WAIT_CYCLES > POWERUP_CYCLES) ? CLEAR_WAIT_CYCLES : POWERUP_CYCLES;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'((POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] EN_LAST  = CW'((EN_HIGH_CYCLES > 0) ? EN_HIGH_CYCLES - 1 : 0);
    localparam logic [CW-1:0] CMD_W    = CW'(CMD_WAIT_CYCLES);
    localparam logic [CW-1:0] CLEAR_W  = CW'(CLEAR_WAIT_CYCLES);
    localparam logic [6:0]    COL_ADDR = 7'(START_COL);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHARS
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } phase_t;

    state_t        state, state_n;
    phase_t        phase, phase_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [31:0]   snapshot, snap_n;
    logic          init_done_n;
    logic [7:0]    count_n;
    logic          load_byte;
    logic          byte_done;
    logic [CW-1:0] wait_len;

    // Byte (with its rs bit) that a given state/index position sends. Init
    // commands: function set 8-bit/2-line/5x8, display on, clear, entry mode.
    function automatic logic [8:0] byte_for(input state_t st, input logic [1:0] i,
                                            input logic [31:0] snap);
        logic [8:0] b;
        b = 9'h000;
        case (st)
            ST_INIT: begin
                case (i)
                    2'd0:    b = 9'h038;
                    2'd1:    b = 9'h00C;
                    2'd2:    b = 9'h001;
                    default: b = 9'h006;
                endcase
            end
            ST_ADDR:  b = {2'b01, COL_ADDR};
            ST_CHARS: begin
                case (i)
                    2'd0:    b = {1'b1, snap[31:24]};
                    2'd1:    b = {1'b1, snap[23:16]};
                    2'd2:    b = {1'b1, snap[15:8]};
                    default: b = {1'b1, snap[7:0]};
                endcase
            end
            default:  b = 9'h000;
        endcase
        return b;
    endfunction

    // The clear command needs the long wait; decided from the byte currently
    // on the bus, which is stable for the whole transfer.
    assign wait_len = (!lcd_rs && (lcd_data == 8'h01)) ? CLEAR_W : CMD_W;

    assign lcd_rw = 1'b0;

    // Next-state logic for the top FSM and the SETUP/PULSE/WAIT byte engine.
    // Whenever a transfer is about to enter SETUP, load_byte requests that the
    // new byte be latched onto the bus in the same edge.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        cnt_n       = cnt;
        idx_n       = idx;
        snap_n      = snapshot;
        init_done_n = init_done;
        count_n     = update_count;
        load_byte   = 1'b0;
        byte_done   = 1'b0;

        case (state)
            ST_POWERUP: begin
                if (cnt >= PWR_LAST) begin
                    state_n   = ST_INIT;
                    phase_n   = PH_SETUP;
                    idx_n     = 2'd0;
                    cnt_n     = '0;
                    load_byte = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (note_chars != snapshot) begin
                    snap_n    = note_chars;
                    state_n   = ST_ADDR;
                    phase_n   = PH_SETUP;
                    idx_n     = 2'd0;
                    cnt_n     = '0;
                    load_byte = 1'b1;
                end
            end
            default: begin
                case (phase)
                    PH_SETUP: begin
                        phase_n = PH_PULSE;
                        cnt_n   = '0;
                    end
                    PH_PULSE: begin
                        if (cnt >= EN_LAST) begin
                            if (wait_len == '0) begin
                                byte_done = 1'b1;
                            end else begin
                                phase_n = PH_WAIT;
                                cnt_n   = '0;
                            end
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    PH_WAIT: begin
                        if (cnt >= wait_len - 1'b1) begin
                            byte_done = 1'b1;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    default: begin
                        phase_n = PH_SETUP;
                    end
                endcase
            end
        endcase

        // End of a byte: advance through the command/character lists.
        if (byte_done) begin
            cnt_n   = '0;
            phase_n = PH_SETUP;
            case (state)
                ST_INIT: begin
                    if (idx == 2'd3) begin
                        init_done_n = 1'b1;
                        state_n     = ST_ADDR;
                        idx_n       = 2'd0;
                        snap_n      = note_chars;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                    load_byte = 1'b1;
                end
                ST_ADDR: begin
                    state_n   = ST_CHARS;
                    idx_n     = 2'd0;
                    load_byte = 1'b1;
                end
                ST_CHARS: begin
                    if (idx == 2'd3) begin
                        count_n = update_count + 8'd1;
                        state_n = ST_IDLE;
                    end else begin
                        idx_n     = idx + 2'd1;
                        load_byte = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers. lcd_en and busy are registered from the
    // next-state values so the LCD pins are glitch-free; the async reset pulls
    // lcd_en low immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_POWERUP;
            phase        <= PH_SETUP;
            cnt          <= '0;
            idx          <= 2'd0;
            snapshot     <= 32'h20202020;
            lcd_data     <= 8'h00;
            lcd_rs       <= 1'b0;
            lcd_en       <= 1'b0;
            init_done    <= 1'b0;
            busy         <= 1'b1;
            update_count <= 8'd0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            cnt          <= cnt_n;
            idx          <= idx_n;
            snapshot     <= snap_n;
            init_done    <= init_done_n;
            update_count <= count_n;
            busy         <= (state_n != ST_IDLE);
            lcd_en       <= (phase_n == PH_PULSE) &&
                            ((state_n == ST_INIT) || (state_n == ST_ADDR) || (state_n == ST_CHARS));
            if (load_byte) begin
                {lcd_rs, lcd_data} <= byte_for(state_n, idx_n, snap_n);
            end
        end
    end

endmodule
